approx_mul_pipe: RTL and testbench
==================================

Name: approx_mul_pipe

Overview:
- Parametrised, pipelined unsigned WxW multiplier with run-time selection between exact and approximate modes.
- Successor to the fixed 8x8 half-adder-array partial-product generators. Adds a generic width, per-transaction mode select, a valid/ready stream handshake and a completed-transaction counter.
- Sits between operand producers and the accumulation datapath.
- Produces a full 2W-bit product with fixed 3-cycle latency.

Parameters:
- W, 8, operand width; must be even, range 4..16.
- OR_COLS, 6, in approx mode, absolute product columns below this index use an OR cell instead of a half adder.
- TRUNC_COLS, 0, in approx mode, partial-product bits in absolute columns below this index are forced to 0; must be <= OR_COLS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_x  in  W  multiplicand.
- in_y  in  W  multiplier.
- in_mode  in  1  0 = exact, 1 = approximate; captured with the operands.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  2W  product.
- out_mode  out  1  mode of this product.
- done_cnt  out  16  count of completed output handshakes; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release)
  - All stage valid bits = 0, out_valid = 0, out_p = 0, out_mode = 0, done_cnt = 0.
  - in_ready = 1 once rst_n is high.
  - Reset asserted mid-operation discards every in-flight beat; nothing is emitted after release.
- Handshake
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - Accept occurs when in_valid & in_ready at a clock edge.
  - When stall = 0, all stages advance each edge; bubbles (invalid stages) advance too and are not collapsed.
  - When stall = 1, all stage registers, including out_p and out_mode, hold.
  - in_valid without in_ready: no capture.
- Stage S1 (edge of accept)
  - Register x, y, mode and valid.
- Stage S2: half-adder-array compression, one pair per row pair r = 0..W/2-1.
  - a_c = x[2r] & y[c] for c = 0..W-1, else 0.
  - b_c = x[2r+1] & y[c-1] for c = 1..W, else 0.
  - Absolute column k = 2r + c.
  - If mode = 1 and k < TRUNC_COLS: a_c = b_c = 0.
  - If mode = 1 and k < OR_COLS: s_c = a_c | b_c, carry_c = 0. Otherwise {carry_c, s_c} = a_c + b_c.
  - Register P_r = sum over c of (s_c + 2*carry_c) << c, width W+2.
- Stage S3
  - out_p = (sum over r of P_r << 2r) mod 2^(2W); out_mode and out_valid follow.
- Latency and throughput
  - Accept at edge n gives out_valid high after edge n+2 (product visible in the cycle following the third register stage edge), assuming no stall.
  - Throughput is 1 beat per cycle.
- Mode results
  - Exact mode: out_p = x*y bit-exact.
  - Approx mode: out_p <= x*y always; the error comes only from the OR and truncation columns.
- done_cnt
  - Increments on every edge with out_valid & out_ready; holds at 0xFFFF.
- Simultaneous events
  - Output handshake and new accept on the same edge are both honoured.
  - Mode may change on every beat; each product carries its own out_mode.

Test Plan:
- Exact, W=8: x=0xFF, y=0xFF, mode=0, out_ready=1 -> out_p=0xFE01, out_mode=0, 3 cycles after accept; done_cnt=1.
- Approx, defaults: x=0x03, y=0x03, mode=1 -> out_p=0x0007 (exact 9). Then x=0x03, y=0x01, mode=1 -> out_p=0x0003. Then x=0x80, y=0x80, mode=1 -> out_p=0x4000.
- Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 while stalled, out_p stable, no beat lost or duplicated; on release, products emerge in order, 1 per cycle.
- Reset mid-flight: accept 2 beats, pull rst_n low asynchronously between edges -> out_valid=0 and done_cnt=0 immediately; no output after release until a new accept.
- Counter saturation: preload via 65 537 handshakes (or force) -> done_cnt stops at 0xFFFF.
- Random regression over W in {4, 8, 16} and OR/TRUNC settings against a bit-level reference model of the S2 rules -> zero mismatches; mode=0 always equals x*y.

Source files
------------

// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned WxW multiplier, exact or approximate per beat.
// Stages: operand capture, half-adder row-pair compression, final summation.
module approx_mul_pipe #(
   parameter int W          = 8,
   parameter int OR_COLS    = 6,
   parameter int TRUNC_COLS = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_x,
   input  logic [W-1:0]     in_y,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_p,
   output logic             out_mode,
   output logic [15:0]      done_cnt
);

   localparam int R  = W / 2;
   localparam int PW = W + 2;

   // Handshake: a beat moves on an edge with valid & ready high. The whole
   // pipeline freezes while the output holds a product the consumer refuses.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   logic            s1_valid;
   logic [W-1:0]    s1_x;
   logic [W-1:0]    s1_y;
   logic            s1_mode;

   logic            s2_valid;
   logic            s2_mode;
   logic [PW-1:0]   s2_p [R];
   logic [PW-1:0]   pp_next [R];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_mode  <= 1'b0;
      end else if (!stall) begin
         s1_valid <= in_valid;
         s1_x     <= in_x;
         s1_y     <= in_y;
         s1_mode  <= in_mode;
      end
   end

   // Row pair r: a = x[2r] row at column c, b = x[2r+1] row shifted one left.
   for (genvar r = 0; r < R; r++) begin : g_row
      logic [W:0] a_v;
      logic [W:0] b_v;
      logic [W:0] s_v;
      logic [W:0] c_v;
      assign a_v = {1'b0, s1_y} & {(W+1){s1_x[2*r]}};
      assign b_v = {s1_y, 1'b0} & {(W+1){s1_x[2*r+1]}};
      for (genvar c = 0; c <= W; c++) begin : g_col
         localparam logic TRUNC_COL = ((2*r + c) < TRUNC_COLS);
         localparam logic OR_COL    = ((2*r + c) < OR_COLS);
         logic a_m;
         logic b_m;
         logic or_sel;
         assign a_m    = a_v[c] & ~(s1_mode & TRUNC_COL);
         assign b_m    = b_v[c] & ~(s1_mode & TRUNC_COL);
         assign or_sel = s1_mode & OR_COL;
         assign s_v[c] = or_sel ? (a_m | b_m) : (a_m ^ b_m);
         assign c_v[c] = or_sel ? 1'b0 : (a_m & b_m);
      end
      assign pp_next[r] = PW'(s_v) + {c_v, 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_mode  <= 1'b0;
         s2_p     <= '{default: '0};
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_mode  <= s1_mode;
         s2_p     <= pp_next;
      end
   end

   // Final adder chain: each row-pair result weighs 4^r.
   logic [2*W-1:0] acc_v [R+1];
   assign acc_v[0] = '0;
   for (genvar r = 0; r < R; r++) begin : g_sum
      assign acc_v[r+1] = acc_v[r] + ((2*W)'(s2_p[r]) << (2*r));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_p     <= '0;
         out_mode  <= 1'b0;
      end else if (!stall) begin
         out_valid <= s2_valid;
         out_p     <= acc_v[R];
         out_mode  <= s2_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (out_valid && out_ready && (done_cnt != 16'hFFFF)) begin
         done_cnt <= done_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Bench for approx_mul_pipe: directed vector tables on a W=8 and a W=4
// instance, plus latency, backpressure, mid-flight reset and saturation sequences.
module tb_approx_mul_pipe;

   localparam int W  = 8;
   localparam int WB = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
   logic [W-1:0]      in_x, in_y;
   logic [2*W-1:0]    out_p;
   logic [15:0]       done_cnt;

   logic              in_valid_b, in_ready_b, in_mode_b, out_valid_b, out_ready_b, out_mode_b;
   logic [WB-1:0]     in_x_b, in_y_b;
   logic [2*WB-1:0]   out_p_b;
   logic [15:0]       done_cnt_b;

   approx_mul_pipe #(.W(W), .OR_COLS(6), .TRUNC_COLS(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .out_mode(out_mode), .done_cnt(done_cnt));

   approx_mul_pipe #(.W(WB), .OR_COLS(3), .TRUNC_COLS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_x(in_x_b), .in_y(in_y_b), .in_mode(in_mode_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_p(out_p_b), .out_mode(out_mode_b), .done_cnt(done_cnt_b));

   typedef struct { logic [W-1:0] x; logic [W-1:0] y; logic mode; logic [2*W-1:0] p; } vec_t;
   typedef struct { logic [WB-1:0] x; logic [WB-1:0] y; logic mode; logic [2*WB-1:0] p; } vec_b_t;

   vec_t   tbl   [12];
   vec_t   bp    [5];
   vec_b_t tbl_b [10];

   int   n_cmp = 0;
   int   n_bad = 0;
   logic check_en = 1'b1;
   logic [2*W:0]  exp_q[$];
   logic [2*WB:0] exp_b_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Scoreboards: compare every output handshake against the expected queue.
   always @(negedge clk) begin
      if (rst_n && check_en && out_valid && out_ready) begin
         logic [2*W:0] e;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got 0x%0h, expected no product", out_p);
         end else begin
            e = exp_q.pop_front();
            check("out_p", 32'(out_p), 32'(e[2*W-1:0]));
            check("out_mode", 32'(out_mode), 32'(e[2*W]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid_b && out_ready_b) begin
         logic [2*WB:0] e;
         if (exp_b_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_b: got 0x%0h, expected no product", out_p_b);
         end else begin
            e = exp_b_q.pop_front();
            check("out_p_b", 32'(out_p_b), 32'(e[2*WB-1:0]));
            check("out_mode_b", 32'(out_mode_b), 32'(e[2*WB]));
         end
      end
   end

   // Drivers: called just after a rising edge, return just after the accepting edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
      bit ok;
      int guard;
      in_x = x; in_y = y; in_mode = m; in_valid = 1'b1;
      ok = 1'b0; guard = 0;
      while (!ok && guard < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!ok) timeout("send");
   endtask

   task automatic send_b(input logic [WB-1:0] x, input logic [WB-1:0] y, input logic m);
      bit ok;
      int guard;
      in_x_b = x; in_y_b = y; in_mode_b = m; in_valid_b = 1'b1;
      ok = 1'b0; guard = 0;
      while (!ok && guard < 50) begin
         @(negedge clk);
         ok = in_ready_b;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!ok) timeout("send_b");
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while ((exp_q.size() != 0 || exp_b_q.size() != 0) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) timeout(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0]   held;
      logic [W-1:0]   rx, ry;
      logic [2*W-1:0] held_p;
      int g;

      tbl[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      tbl[1]  = '{8'h00, 8'h5A, 1'b0, 16'h0000};
      tbl[2]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
      tbl[3]  = '{8'hAB, 8'h01, 1'b0, 16'h00AB};
      tbl[4]  = '{8'h80, 8'hFF, 1'b0, 16'h7F80};
      tbl[5]  = '{8'h10, 8'h10, 1'b0, 16'h0100};
      tbl[6]  = '{8'h03, 8'h03, 1'b1, 16'h0007};
      tbl[7]  = '{8'h03, 8'h01, 1'b1, 16'h0003};
      tbl[8]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
      tbl[9]  = '{8'hFF, 8'hFF, 1'b1, 16'hFD6B};
      tbl[10] = '{8'h0F, 8'h0F, 1'b1, 16'h009B};
      tbl[11] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1};

      bp[0] = '{8'h11, 8'h02, 1'b0, 16'h0022};
      bp[1] = '{8'h21, 8'h03, 1'b0, 16'h0063};
      bp[2] = '{8'h03, 8'h03, 1'b1, 16'h0007};
      bp[3] = '{8'h40, 8'h04, 1'b0, 16'h0100};
      bp[4] = '{8'h0F, 8'h0F, 1'b1, 16'h009B};

      // W=4, OR_COLS=3, TRUNC_COLS=2
      tbl_b[0] = '{4'hF, 4'hF, 1'b0, 8'hE1};
      tbl_b[1] = '{4'h5, 4'h6, 1'b0, 8'h1E};
      tbl_b[2] = '{4'h9, 4'hC, 1'b0, 8'h6C};
      tbl_b[3] = '{4'h1, 4'h1, 1'b0, 8'h01};
      tbl_b[4] = '{4'hF, 4'hF, 1'b1, 8'hD8};
      tbl_b[5] = '{4'h3, 4'h3, 1'b1, 8'h04};
      tbl_b[6] = '{4'h5, 4'h6, 1'b1, 8'h1C};
      tbl_b[7] = '{4'h1, 4'h1, 1'b1, 8'h00};
      tbl_b[8] = '{4'h8, 4'h8, 1'b1, 8'h40};
      tbl_b[9] = '{4'h0, 4'hF, 1'b1, 8'h00};

      in_valid = 1'b0; in_x = '0; in_y = '0; in_mode = 1'b0; out_ready = 1'b1;
      in_valid_b = 1'b0; in_x_b = '0; in_y_b = '0; in_mode_b = 1'b0; out_ready_b = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_p", 32'(out_p), 32'd0);
      check("rst_out_mode", 32'(out_mode), 32'd0);
      check("rst_done_cnt", 32'(done_cnt), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency of a single exact beat
      exp_q.push_back({1'b0, 16'hFE01});
      in_x = 8'hFF; in_y = 8'hFF; in_mode = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("lat_valid_n1", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("lat_valid_n2", 32'(out_valid), 32'd1);
      check("lat_out_p", 32'(out_p), 32'h0000FE01);
      check("lat_out_mode", 32'(out_mode), 32'd0);
      @(posedge clk);
      #1;
      check("lat_done_cnt", 32'(done_cnt), 32'd1);
      check("lat_valid_n3", 32'(out_valid), 32'd0);

      // Table vectors, back to back
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back({tbl[i].mode, tbl[i].p});
         send(tbl[i].x, tbl[i].y, tbl[i].mode);
      end
      in_valid = 1'b0;
      drain("drain_tbl");
      check("tbl_done_cnt", 32'(done_cnt), 32'd13);

      // Backpressure: stall 4 cycles once the first product shows
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               exp_q.push_back({bp[i].mode, bp[i].p});
               send(bp[i].x, bp[i].y, bp[i].mode);
            end
            in_valid = 1'b0;
         end
         begin
            g = 0;
            while (!out_valid && g < 20) begin
               @(posedge clk);
               #1;
               g++;
            end
            if (g >= 20) timeout("bp_wait_valid");
            out_ready = 1'b0;
            held_p = out_p;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               check("bp_in_ready", 32'(in_ready), 32'd0);
               check("bp_out_valid", 32'(out_valid), 32'd1);
               check("bp_out_p_hold", 32'(out_p), 32'(held_p));
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check("bp_release_stream", 32'(out_valid), 32'd1);
            end
         end
      join
      drain("drain_bp");
      check("bp_done_cnt", 32'(done_cnt), 32'd18);

      // Reset asserted mid-flight
      exp_q.push_back({1'b0, 16'h0022});
      send(8'h11, 8'h02, 1'b0);
      send(8'h05, 8'h05, 1'b0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_pre_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_done_cnt", 32'(done_cnt), 32'd0);
      check("mid_out_p", 32'(out_p), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("mid_no_output", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Exact-mode random beats
      for (int i = 0; i < 40; i++) begin
         rx = W'($urandom_range(0, 255));
         ry = W'($urandom_range(0, 255));
         exp_q.push_back({1'b0, 16'(rx) * 16'(ry)});
         send(rx, ry, 1'b0);
      end
      in_valid = 1'b0;
      drain("drain_rand");
      check("rand_done_cnt", 32'(done_cnt), 32'd40);

      // W=4 instance with truncation and OR columns
      for (int i = 0; i < 10; i++) begin
         exp_b_q.push_back({tbl_b[i].mode, tbl_b[i].p});
         send_b(tbl_b[i].x, tbl_b[i].y, tbl_b[i].mode);
      end
      in_valid_b = 1'b0;
      drain("drain_b");
      check("b_done_cnt", 32'(done_cnt_b), 32'd10);

      // Counter saturation through continuous handshakes
      check_en = 1'b0;
      in_x = '0; in_y = '0; in_mode = 1'b0; in_valid = 1'b1;
      g = 0;
      while (done_cnt != 16'hFFFF && g < 70000) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (g >= 70000) timeout("sat_reach");
      repeat (4) @(posedge clk);
      #1;
      check("sat_streaming", 32'(out_valid), 32'd1);
      check("sat_done_cnt", 32'(done_cnt), 32'h0000FFFF);
      in_valid = 1'b0;
      held = '0;
      if (held != '0) timeout("unreachable");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
